// File: rtl/sa_pkg.sv
// Shared defaults and state types for the systolic-array front end.
package sa_pkg;

   localparam int unsigned SA_SIZE = 4;
   localparam int unsigned SA_DW   = 8;

   typedef enum logic [1:0] {
      IDLE,
      WLOAD,
      XFEED,
      DRAIN
   } fsm_state_t;

   typedef enum logic [1:0] {
      ACC,
      STRB,
      HOLD
   } wload_phase_t;

endpackage

// File: rtl/sa_feeder_skew_line.sv
// Fixed-depth delay line for one activation lane, carrying a valid bit alongside the data.
module skew_line #(
   parameter int unsigned DEPTH = 1,
   parameter int unsigned DW    = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic [DW-1:0] d,
   input  logic          d_valid,
   output logic [DW-1:0] q,
   output logic          q_valid
);

   if (DEPTH == 0) begin : g_wire
      logic unused;
      assign unused  = &{1'b0, clk, rst, en};
      assign q       = d;
      assign q_valid = d_valid;
   end else begin : g_shift
      logic [DW-1:0] data [DEPTH];
      logic          vld  [DEPTH];

      always_ff @(posedge clk) begin
         if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
               data[i] <= '0;
               vld[i]  <= 1'b0;
            end
         end else if (en) begin
            data[0] <= d;
            vld[0]  <= d_valid;
            for (int unsigned i = 1; i < DEPTH; i++) begin
               data[i] <= data[i-1];
               vld[i]  <= vld[i-1];
            end
         end
      end

      assign q       = data[DEPTH-1];
      assign q_valid = vld[DEPTH-1];
   end

endmodule

// File: rtl/sa_feeder.sv
// Weight preload and skewed activation feed sequencer for the systolic array.
module sa_feeder
   import sa_pkg::*;
#(
   parameter int unsigned SIZE = SA_SIZE,
   parameter int unsigned DW   = SA_DW
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic               busy,
   output logic               done,
   input  logic               w_valid,
   output logic               w_ready,
   input  logic [SIZE*DW-1:0] w_data,
   input  logic               x_valid,
   output logic               x_ready,
   input  logic [SIZE*DW-1:0] x_data,
   output logic               preclk,
   output logic [SIZE*DW-1:0] weight_in,
   output logic [SIZE*DW-1:0] in_in,
   output logic               in_active
);

   localparam int unsigned   CW         = (SIZE > 1) ? $clog2(SIZE) : 1;
   localparam logic [CW-1:0] LAST_ROW   = CW'(SIZE - 1);
   localparam logic [CW-1:0] LAST_DRAIN = CW'(SIZE - 2);

   fsm_state_t          state;
   wload_phase_t        phase;
   logic [CW-1:0]       cnt;
   logic                x_fire;
   logic                shift_en;
   logic [SIZE*DW-1:0]  skew_q;
   logic [SIZE-1:0]     skew_v;

   assign x_fire   = (state == XFEED) && x_ready && x_valid;
   assign shift_en = (state == XFEED) || (state == DRAIN);

   // cnt counts weight rows in WLOAD, accepted rows in XFEED and drain cycles in DRAIN
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         phase     <= ACC;
         cnt       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         preclk    <= 1'b0;
         w_ready   <= 1'b0;
         x_ready   <= 1'b0;
         weight_in <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= WLOAD;
                  phase   <= ACC;
                  cnt     <= '0;
                  busy    <= 1'b1;
                  w_ready <= 1'b1;
               end
            end
            WLOAD: begin
               case (phase)
                  ACC: begin
                     if (w_valid && w_ready) begin
                        weight_in <= w_data;
                        w_ready   <= 1'b0;
                        phase     <= STRB;
                     end
                  end
                  STRB: begin
                     preclk <= 1'b1;
                     phase  <= HOLD;
                  end
                  HOLD: begin
                     preclk <= 1'b0;
                     if (cnt == LAST_ROW) begin
                        state   <= XFEED;
                        cnt     <= '0;
                        x_ready <= 1'b1;
                     end else begin
                        cnt     <= cnt + 1'b1;
                        phase   <= ACC;
                        w_ready <= 1'b1;
                     end
                  end
                  default: phase <= ACC;
               endcase
            end
            XFEED: begin
               if (x_fire) begin
                  if (cnt == LAST_ROW) begin
                     state   <= DRAIN;
                     cnt     <= '0;
                     x_ready <= 1'b0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (cnt == LAST_DRAIN) begin
                  state     <= IDLE;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  weight_in <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   for (genvar j = 0; j < SIZE; j++) begin : g_lane
      skew_line #(
         .DEPTH (j),
         .DW    (DW)
      ) u_skew (
         .clk     (clk),
         .rst     (rst),
         .en      (shift_en),
         .d       (x_fire ? x_data[j*DW +: DW] : '0),
         .d_valid (x_fire),
         .q       (skew_q[j*DW +: DW]),
         .q_valid (skew_v[j])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         in_in     <= '0;
         in_active <= 1'b0;
      end else begin
         in_in     <= skew_q;
         in_active <= |skew_v;
      end
   end

endmodule

// File: tb/tb_sa_feeder.sv
// Bench for sa_feeder: timestamp-based reference model compared every cycle, plus directed literal checks.
module tb_sa_feeder;

   localparam int SIZE = 4;
   localparam int DW   = 8;
   localparam int W    = SIZE * DW;
   localparam int MAXC = 4096;

   logic         clk = 1'b0;
   logic         rst, start, w_valid, x_valid;
   logic [W-1:0] w_data, x_data;
   logic         busy, done, w_ready, x_ready, preclk, in_active;
   logic [W-1:0] weight_in, in_in;

   sa_feeder #(.SIZE(SIZE), .DW(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .w_valid   (w_valid),
      .w_ready   (w_ready),
      .w_data    (w_data),
      .x_valid   (x_valid),
      .x_ready   (x_ready),
      .x_data    (x_data),
      .preclk    (preclk),
      .weight_in (weight_in),
      .in_in     (in_in),
      .in_active (in_active)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit chk_en = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: edge timestamps of handshakes ----------------
   int           e = 0, last_rst = -1;
   int           w_cnt = 0, x_cnt = 0, w_last = 0, x_last = 0;
   bit           in_job = 0;
   logic [W-1:0] w_row = '0;
   logic [W-1:0] hist_d [MAXC];
   bit           hist_v [MAXC];
   bit           exp_busy = 0, exp_done = 0, exp_w_ready = 0, exp_x_ready = 0;
   bit           exp_preclk = 0, exp_act = 0;
   logic [W-1:0] exp_weight = '0, exp_in = '0;

   initial for (int i = 0; i < MAXC; i++) begin
      hist_d[i] = '0;
      hist_v[i] = 0;
   end

   always @(posedge clk) begin : model
      bit fin;
      fin = 0;
      e++;
      if (rst) begin
         in_job = 0; w_cnt = 0; x_cnt = 0; w_row = '0; last_rst = e;
      end else if (in_job) begin
         if (exp_w_ready && w_valid) begin
            w_row = w_data; w_cnt++; w_last = e;
         end
         if (exp_x_ready && x_valid && e < MAXC) begin
            hist_d[e] = x_data; hist_v[e] = 1; x_cnt++; x_last = e;
         end
         if (x_cnt == SIZE && e == x_last + SIZE - 1) begin
            in_job = 0; fin = 1; w_row = '0;
         end
      end else if (start) begin
         in_job = 1; w_cnt = 0; x_cnt = 0; w_row = '0;
      end
      exp_busy    = in_job;
      exp_done    = fin;
      exp_w_ready = in_job && w_cnt < SIZE && (w_cnt == 0 || e >= w_last + 2);
      exp_preclk  = in_job && w_cnt > 0 && e == w_last + 1;
      exp_x_ready = in_job && w_cnt == SIZE && e >= w_last + 2 && x_cnt < SIZE;
      exp_weight  = w_row;
      exp_in      = '0;
      exp_act     = 0;
      for (int j = 0; j < SIZE; j++) begin
         if (e - j > last_rst && e - j >= 0 && e - j < MAXC && hist_v[e-j]) begin
            exp_in[j*DW +: DW] = hist_d[e-j][j*DW +: DW];
            exp_act = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("busy",      {63'd0, busy},      {63'd0, exp_busy});
         check("done",      {63'd0, done},      {63'd0, exp_done});
         check("w_ready",   {63'd0, w_ready},   {63'd0, exp_w_ready});
         check("x_ready",   {63'd0, x_ready},   {63'd0, exp_x_ready});
         check("preclk",    {63'd0, preclk},    {63'd0, exp_preclk});
         check("in_active", {63'd0, in_active}, {63'd0, exp_act});
         check("weight_in", 64'(weight_in),     64'(exp_weight));
         check("in_in",     64'(in_in),         64'(exp_in));
      end
   end

   // ---------------- stimulus ----------------
   function automatic logic [W-1:0] wrow(input int r);
      logic [W-1:0] v;
      v = '0;
      for (int j = 0; j < SIZE; j++) v[j*DW +: DW] = DW'(r * SIZE + j + 1);
      return v;
   endfunction

   function automatic logic [W-1:0] xrow(input int r);
      logic [W-1:0] v;
      v = '0;
      for (int j = 0; j < SIZE; j++) v[j*DW +: DW] = DW'(-(r * SIZE + j + 1));
      return v;
   endfunction

   int           t_done, t_xr, n_pre, n_done, n_act, first_act;
   logic [W-1:0] obs_pw [SIZE];
   logic [W-1:0] obs_fc [8];
   logic [5:0]   obs_rst_flags;
   logic [W-1:0] obs_rst_w, obs_rst_in;

   // cycle 0 carries start; observations are the outputs seen during cycle c
   task automatic run_job(input int w_hold, input int x_hold, input int rst_at, input int restart_at);
      int  wr, xr, wh, xh;
      bit  fin, fw, fx;
      wr = 0; xr = 0; wh = w_hold; xh = x_hold; fin = 0;
      t_done = -1; t_xr = -1; n_pre = 0; n_done = 0; n_act = 0; first_act = -1;
      obs_rst_flags = '1; obs_rst_w = '1; obs_rst_in = '1;
      for (int i = 0; i < 8; i++) obs_fc[i] = '0;
      for (int i = 0; i < SIZE; i++) obs_pw[i] = '0;
      for (int c = 0; c < 100 && !fin; c++) begin
         start   = (c == 0) || (c == restart_at);
         rst     = (c == rst_at);
         w_valid = (wr < SIZE) && !(wr == 2 && wh > 0);
         w_data  = wrow(wr);
         x_valid = (xr < SIZE) && !(xr == 2 && xh > 0);
         x_data  = xrow(xr);
         if (done) begin
            n_done++;
            if (t_done < 0) t_done = c;
         end
         if (x_ready && t_xr < 0) t_xr = c;
         if (preclk) begin
            if (n_pre < SIZE) obs_pw[n_pre] = weight_in;
            n_pre++;
         end
         if (in_active) begin
            n_act++;
            if (first_act < 0) first_act = c;
         end
         if (first_act >= 0 && c - first_act < 8) obs_fc[c-first_act] = in_in;
         if (rst_at >= 0 && c == rst_at + 1) begin
            obs_rst_flags = {busy, done, preclk, w_ready, x_ready, in_active};
            obs_rst_w     = weight_in;
            obs_rst_in    = in_in;
         end
         fw = w_valid && w_ready;
         fx = x_valid && x_ready;
         @(posedge clk);
         #1;
         if (fw) wr++;
         else if (wr == 2 && wh > 0) wh--;
         if (fx) xr++;
         else if (xr == 2 && xh > 0) xh--;
         if (t_done >= 0 && c >= t_done + 2) fin = 1;
         if (rst_at >= 0 && c >= rst_at + 3) fin = 1;
      end
      start = 0; rst = 0; w_valid = 0; x_valid = 0;
      check("job_terminated", {63'd0, fin}, 64'd1);
   endtask

   task automatic check_baseline(input string tag);
      check({tag, "_done_cycle"}, 64'(t_done), 64'd20);
      check({tag, "_xfeed_cycle"}, 64'(t_xr), 64'd13);
      check({tag, "_preclk_pulses"}, 64'(n_pre), 64'd4);
      check({tag, "_w_row0"}, 64'(obs_pw[0]), 64'h04030201);
      check({tag, "_w_row1"}, 64'(obs_pw[1]), 64'h08070605);
      check({tag, "_w_row2"}, 64'(obs_pw[2]), 64'h0C0B0A09);
      check({tag, "_w_row3"}, 64'(obs_pw[3]), 64'h100F0E0D);
      check({tag, "_active_cycles"}, 64'(n_act), 64'd7);
      check({tag, "_feed0"}, 64'(obs_fc[0]), 64'h000000FF);
      check({tag, "_feed3"}, 64'(obs_fc[3]), 64'hFCF9F6F3);
      check({tag, "_feed6"}, 64'(obs_fc[6]), 64'hF0000000);
      check({tag, "_feed7"}, 64'(obs_fc[7]), 64'h00000000);
      check({tag, "_done_count"}, 64'(n_done), 64'd1);
   endtask

   task automatic check_reset_cut(input string tag);
      check({tag, "_flags"}, 64'(obs_rst_flags), 64'd0);
      check({tag, "_weight_in"}, 64'(obs_rst_w), 64'd0);
      check({tag, "_in_in"}, 64'(obs_rst_in), 64'd0);
      check({tag, "_done_count"}, 64'(n_done), 64'd0);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst = 1; start = 0; w_valid = 0; x_valid = 0; w_data = '0; x_data = '0;
      @(posedge clk);
      #1;
      chk_en = 1;
      idle(1);
      rst = 0;
      idle(2);

      run_job(0, 0, -1, 5);
      check_baseline("base");
      idle(3);

      run_job(5, 0, -1, -1);
      check("whold_done_cycle", 64'(t_done), 64'd23);
      check("whold_preclk_pulses", 64'(n_pre), 64'd4);
      check("whold_w_row2", 64'(obs_pw[2]), 64'h0C0B0A09);
      check("whold_done_count", 64'(n_done), 64'd1);
      idle(2);

      run_job(0, 2, -1, -1);
      check("xstall_done_cycle", 64'(t_done), 64'd22);
      check("xstall_active_cycles", 64'(n_act), 64'd9);
      check("xstall_done_count", 64'(n_done), 64'd1);
      idle(2);

      run_job(0, 0, 6, -1);
      check_reset_cut("rst_hold");
      idle(2);

      run_job(0, 0, 18, -1);
      check_reset_cut("rst_drain");
      idle(2);

      run_job(0, 0, -1, -1);
      check_baseline("clean");
      idle(3);

      chk_en = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sa_feeder.md
# sa_feeder

Front-end sequencer for the systolic array `sa`: it preloads the SIZE×SIZE weight matrix row by row, generating the `preclk` strobe, then streams SIZE activation rows into `in_in` with a diagonal skew, where lane j is delayed j cycles. It sits directly upstream of `sa` and drives `preclk`, `weight_in` and `in_in`. On the other side it takes weights and activations from the operand buffers over valid/ready handshakes.

## Interface
- `SIZE`, 4, array dimension (lanes per row, rows per matrix)
- `DW`, 8, operand width per lane
- `clk`  in  1  system clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request to run one weight-load + feed job
- `busy`  out  1  high from the cycle after accepted `start` until `done`
- `done`  out  1  one-cycle pulse at job end
- `w_valid` / `w_ready`  in / out  1 / 1  weight-row handshake
- `w_data`  in  SIZE*DW  weight row; lane j = bits [j*DW +: DW]
- `x_valid` / `x_ready`  in / out  1 / 1  activation-row handshake
- `x_data`  in  SIZE*DW  activation row, same lane packing
- `preclk`  out  1  weight shift strobe to `sa`, registered
- `weight_in`  out  SIZE*DW  weight row to `sa`, registered
- `in_in`  out  SIZE*DW  skewed activation lanes to `sa`, registered
- `in_active`  out  1  high while any `in_in` lane carries accepted data

## Operation
- FSM: IDLE → WLOAD → XFEED → DRAIN → IDLE.
- IDLE
  - `start`=1 → WLOAD next cycle.
  - `start` in any other state is ignored.
- WLOAD: row counter r = 0..SIZE-1, sub-phases ACC, STRB, HOLD.
  - ACC: `w_ready`=1. On `w_valid&&w_ready`, `weight_in` ← `w_data` → STRB.
  - STRB: `preclk`=1 for exactly one cycle → HOLD.
  - HOLD: `preclk`=0 and `weight_in` unchanged for one cycle. Then r++ and back to ACC, or to XFEED after r=SIZE-1.
  - Rows are presented in order 0..SIZE-1.
- XFEED: `x_ready`=1 until SIZE rows are accepted.
  - Each cycle, lane 0 of the skew input takes `x_data` lane 0 if a row is accepted, else 0 (a bubble).
  - Lane j output = lane j input delayed j cycles; lane 0 has zero added delay beyond the output register.
  - A bubble injects a zero row. It is harmless for accumulation, and diagonal alignment is kept because every lane shifts every cycle.
- DRAIN: shift zeros for SIZE-1 cycles so the last row's lane SIZE-1 reaches `in_in`. Then `done`=1 for one cycle → IDLE.
- Skew registers always shift in XFEED and DRAIN. They hold zero in IDLE and WLOAD.
- No arithmetic: data passes through unmodified; sign interpretation is left to `sa`.

## Timing
- Reset and IDLE values: `busy`, `done`, `preclk`, `w_ready`, `x_ready`, `in_active` = 0; `weight_in`, `in_in` and all skew registers = 0.
- `weight_in` is stable for one full cycle before `preclk` rises and one full cycle after it falls.
- Weight-load phase takes at least 3 cycles per row, so 3·SIZE cycles with `w_valid` held high.
- Row i lane j appears on `in_in` exactly i+j cycles (plus stall cycles) after row 0's acceptance edge +1.
- Feed plus drain with no stalls takes 2·SIZE-1 cycles. `done` asserts on the cycle after the last drain cycle.
- `in_active` is derived from per-lane valid bits that travel alongside the data in the skew.
- `rst` mid-job: the next cycle is IDLE with all outputs at reset values and skew contents flushed. An in-flight `preclk` pulse is truncated to zero.
- Simultaneous `rst` and `start`: `rst` wins.

## Structure
- Package `sa_pkg`:
  - defaults for `SIZE` and `DW`
  - the FSM state enum (IDLE, WLOAD, XFEED, DRAIN)
  - the WLOAD sub-phase enum (ACC, STRB, HOLD)
- Sub-module `skew_line #(DEPTH, DW)`:
  - a shift register with a valid bit, a synchronous clear on `rst`, and a shift enable
  - instantiated SIZE times with DEPTH=j; DEPTH=0 is a wire-through

## Test plan
- SIZE=4, weights 1..16 row-major, `w_valid` always high → exactly 4 `preclk` pulses. `weight_in` = {4,3,2,1}, {8,7,6,5}, {12,11,10,9}, {16,15,14,13} packed lane0-LSB, each stable through its pulse. XFEED entered 12 cycles after `start`.
- Activations −1..−16 (0xFF..0xF0), `x_valid` always high:
  - row 0: lane 0 = 0xFF at feed cycle 0, lane 3 = 0xFC at feed cycle 3
  - row 3: lane 3 = 0xF0 at feed cycle 6
  - `in_active` high for 7 cycles; `done` pulses once.
- `x_valid` dropped for 2 cycles after row 1 → all lanes for rows 2–3 shift 2 cycles later, with zero rows in the gap. `done` is 2 cycles late.
- `w_valid` low 5 cycles before row 2 → `preclk` is held low, `weight_in` keeps row 1, and `busy` stays high.
- `rst` pulsed during the second `preclk` HOLD and during DRAIN → next cycle all outputs are 0 and state is IDLE. A following clean job reproduces the first scenario exactly.
- `start` reasserted while `busy` → ignored. Exactly one `done` per accepted `start`.
